rotabit_sequencer: RTL and testbench

//  Step controller for a WIDTH-bit rotating-bit register (LED bar / stepper phase pattern).

---
 rtl/rotabit_sequencer.sv | 121 ++++++++++++
 tb/tb_rotabit_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rotabit_sequencer.sv
// Rotating-bit pattern sequencer: loads a start pattern and rotates it left/right
// once per prescaler period, for N steps or continuously, with start/busy/done handshake.
module rotabit_sequencer #(
  parameter int WIDTH   = 16,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   load_pattern,
  input  logic               dir,
  input  logic [CNT_W-1:0]   steps,
  input  logic [PRESC_W-1:0] period,
  input  logic               continuous,
  input  logic               stop,
  output logic [WIDTH-1:0]   pattern,
  output logic               step_pulse,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   pattern_q, pattern_d;
  logic               dir_q, dir_d;
  logic [PRESC_W-1:0] period_q, period_d;
  logic               cont_q, cont_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               step_pulse_q, step_pulse_d;

  logic [WIDTH-1:0]   rot_left, rot_right;
  logic               step_due;

  assign rot_left  = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
  assign rot_right = {pattern_q[0], pattern_q[WIDTH-1:1]};
  // period_q is never 0 once latched, so period_q-1 cannot wrap.
  assign step_due  = (presc_q == period_q - PRESC_ONE);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    pattern_d    = pattern_q;
    dir_d        = dir_q;
    period_d     = period_q;
    cont_d       = cont_q;
    remaining_d  = remaining_q;
    presc_d      = presc_q;
    step_pulse_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          pattern_d   = load_pattern;
          dir_d       = dir;
          period_d    = (period == '0) ? PRESC_ONE : period;
          cont_d      = continuous;
          remaining_d = steps;
          presc_d     = '0;
          state_d     = (steps == '0 && !continuous) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          // Abort outranks a step that falls due on the same edge.
          state_d = ST_DONE;
        end else if (step_due) begin
          presc_d      = '0;
          pattern_d    = dir_q ? rot_right : rot_left;
          step_pulse_d = 1'b1;
          if (!cont_q) begin
            remaining_d = remaining_q - CNT_ONE;
            if (remaining_q == CNT_ONE) state_d = ST_DONE;
          end
        end else begin
          presc_d = presc_q + PRESC_ONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q      <= ST_IDLE;
      pattern_q    <= '0;
      dir_q        <= 1'b0;
      period_q     <= '0;
      cont_q       <= 1'b0;
      remaining_q  <= '0;
      presc_q      <= '0;
      step_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pattern_q    <= pattern_d;
      dir_q        <= dir_d;
      period_q     <= period_d;
      cont_q       <= cont_d;
      remaining_q  <= remaining_d;
      presc_q      <= presc_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign pattern    = pattern_q;
  assign step_pulse = step_pulse_q;
  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_rotabit_sequencer.sv
// Scoreboard bench for rotabit_sequencer: stimulus pushes expected step/done events,
// a negedge monitor pops and compares each one the DUT presents.
module tb_rotabit_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] load_pattern;
  logic        dir;
  logic [7:0]  steps;
  logic [15:0] period;
  logic        continuous;
  logic        stop;
  logic [15:0] pattern;
  logic        step_pulse;
  logic        busy;
  logic        done;

  rotabit_sequencer #(.WIDTH(16), .CNT_W(8), .PRESC_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .load_pattern (load_pattern),
    .dir          (dir),
    .steps        (steps),
    .period       (period),
    .continuous   (continuous),
    .stop         (stop),
    .pattern      (pattern),
    .step_pulse   (step_pulse),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] pat;
    logic        sp;
    logic        dn;
    logic        bz;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_step(input int c, input logic [15:0] p, input logic last);
    exp_t e;
    e.cyc = c; e.pat = p; e.sp = 1'b1; e.dn = last; e.bz = !last;
    sb.push_back(e);
  endtask

  task automatic push_done(input int c, input logic [15:0] p);
    exp_t e;
    e.cyc = c; e.pat = p; e.sp = 1'b0; e.dn = 1'b1; e.bz = 1'b0;
    sb.push_back(e);
  endtask

  // Monitor: every cycle presenting step_pulse or done must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (step_pulse || done)) begin
      if (sb.size() == 0) begin
        check("unexpected_event", {14'd0, step_pulse, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ev_cycle",   cyc,        e.cyc);
        check("ev_pattern", pattern,    e.pat);
        check("ev_step",    step_pulse, e.sp);
        check("ev_done",    done,       e.dn);
        check("ev_busy",    busy,       e.bz);
      end
    end
  end

  // Called at a negedge; the start is sampled on the next posedge. Returns the cycle
  // count at issue time so step n appears at c0 + 1 + n*P.
  task automatic start_run(input logic [15:0] lp, input logic d, input logic [7:0] st,
                           input logic [15:0] per, input logic cont, output int c0);
    load_pattern = lp; dir = d; steps = st; period = per; continuous = cont;
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge clk);
    check("drain_empty", sb.size(), 0);
    if (sb.size() > 0) sb.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; load_pattern = '0; dir = 1'b0;
    steps = '0; period = '0; continuous = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_pattern", pattern, 16'h0000);
    check("rst_busy",    busy,    1'b0);

    // 1: reset mid-activity
    start_run(16'h00F0, 1'b0, 8'd0, 16'd5, 1'b1, c0);
    check("t1_loaded", pattern, 16'h00F0);
    check("t1_busy",   busy,    1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("t1_rst_pattern", pattern,    16'h0000);
    check("t1_rst_busy",    busy,       1'b0);
    check("t1_rst_done",    done,       1'b0);
    check("t1_rst_step",    step_pulse, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 2: left, 4 steps, period 1
    start_run(16'h0001, 1'b0, 8'd4, 16'd1, 1'b0, c0);
    push_step(c0 + 2, 16'h0002, 1'b0);
    push_step(c0 + 3, 16'h0004, 1'b0);
    push_step(c0 + 4, 16'h0008, 1'b0);
    push_step(c0 + 5, 16'h0010, 1'b1);
    drain();
    repeat (3) @(negedge clk);
    check("t2_hold_pattern", pattern, 16'h0010);
    check("t2_idle_busy",    busy,    1'b0);

    // 3: right, 1 step, period 3, wraps bit 0 into MSB
    start_run(16'h0001, 1'b1, 8'd1, 16'd3, 1'b0, c0);
    push_step(c0 + 4, 16'h8000, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      wait_until(c0 + i);
      check("t3_busy",    busy,       1'b1);
      check("t3_no_step", step_pulse, 1'b0);
    end
    drain();

    // 4: continuous left, period 2, stop on a due-step edge
    @(negedge clk);
    start_run(16'h8001, 1'b0, 8'd0, 16'd2, 1'b1, c0);
    push_step(c0 + 3,  16'h0003, 1'b0);
    push_step(c0 + 5,  16'h0006, 1'b0);
    push_step(c0 + 7,  16'h000C, 1'b0);
    push_step(c0 + 9,  16'h0018, 1'b0);
    push_step(c0 + 11, 16'h0030, 1'b0);
    push_done(c0 + 13, 16'h0030);
    wait_until(c0 + 12);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    drain();
    repeat (2) @(negedge clk);
    check("t4_hold_pattern", pattern, 16'h0030);

    // 5a: zero steps, not continuous -> immediate done, pattern loaded
    start_run(16'hA5A5, 1'b0, 8'd0, 16'd4, 1'b0, c0);
    push_done(c0 + 1, 16'hA5A5);
    drain();
    @(negedge clk);
    check("t5_pattern", pattern, 16'hA5A5);
    check("t5_busy",    busy,    1'b0);

    // 5b: period 0 behaves as 1
    start_run(16'h1234, 1'b0, 8'd2, 16'd0, 1'b0, c0);
    push_step(c0 + 2, 16'h2468, 1'b0);
    push_step(c0 + 3, 16'h48D0, 1'b1);
    drain();

    // 6a: start pulse while busy is ignored
    @(negedge clk);
    start_run(16'h0001, 1'b0, 8'd2, 16'd3, 1'b0, c0);
    push_step(c0 + 4, 16'h0002, 1'b0);
    push_step(c0 + 7, 16'h0004, 1'b1);
    wait_until(c0 + 2);
    start_run(16'hFFFF, 1'b1, 8'd9, 16'd1, 1'b1, c0);
    drain();
    repeat (3) @(negedge clk);
    check("t6_hold_pattern", pattern, 16'h0004);

    // 6b: reset during RUN, no done pulse afterwards
    start_run(16'h0001, 1'b0, 8'd5, 16'd2, 1'b0, c0);
    push_step(c0 + 3, 16'h0002, 1'b0);
    push_step(c0 + 5, 16'h0004, 1'b0);
    wait_until(c0 + 6);
    check("t6_prerst_busy", busy, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_rst_pattern", pattern, 16'h0000);
    check("t6_rst_busy",    busy,    1'b0);
    check("t6_rst_done",    done,    1'b0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_queue_empty", sb.size(), 0);
    check("t6_idle_pattern", pattern, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
